if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction fetch front end. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, and receives in-order responses. Fetched instructions are buffered in a small queue and handed to decode over a valid/ready channel. It also accepts branch/jump redirects and exception redirects from later stages.

Parameters:
RESET_PC, 32'h0000_3000, fetch address loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry address
QDEPTH, 2, instruction queue entries (power of two, at least 2)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high; clears all state
pc  output  32  current fetch PC (address of next request)
imem_req_valid  output  1  request pending
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word address; equals pc
imem_rsp_valid  input  1  response data valid; in order, at least 1 cycle after accept
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  branch/jump/eret redirect
redirect_pc  input  32  redirect target
exc_valid  input  1  exception redirect to EXC_VEC
out_valid  output  1  queue head valid
out_instr  output  32  queue head instruction
out_pc  output  32  PC of queue head
out_ready  input  1  decode accepts head

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset values: pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, no outstanding request, drop flag=0. imem_req_valid=0 only while reset is high.
- At most one outstanding request.
- imem_req_valid = !outstanding && (count + 0) < QDEPTH. It is derived from registered state only, with no combinational path from redirect or exc.
- Request accept (valid & ready): outstanding<=1, req_pc<=pc, pc<=pc+4 (wraps mod 2^32).
- Response while outstanding and drop=0: push {req_pc, data} into the queue, outstanding<=0. The entry is visible at out_valid the next cycle (1-cycle registered latency).
- Response while drop=1: discard it, outstanding<=0, drop<=0.
- Pop happens on out_valid & out_ready. Push and pop in the same cycle leave count unchanged.
- Overflow is impossible by the issue rule. Pop on empty and response with no outstanding request are ignored.
- Redirect priority: reset > exc_valid > redirect_valid.
- On a redirect cycle:
  - pc <= target, with low 2 bits forced to 0.
  - Queue flushed, so out_valid=0 next cycle.
  - A same-cycle pop is a no-op.
- Drop handling on a redirect cycle:
  - If a request is outstanding after this cycle, whether pre-existing or accepted this cycle, set drop<=1.
  - A response arriving in the redirect cycle itself is discarded and clears outstanding. If no new request was accepted that cycle, drop stays 0.
- The first request after a redirect is issued no earlier than the next cycle, to the new pc.
- Reset asserted mid-transaction: the in-flight response is ignored. Memory must also be reset by the same reset.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC/EXC_VEC constants, shared with the PC and CP0 logic.
  - fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module, fetch_queue: a synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
- Top level holds the pc register, outstanding/drop flags and redirect priority.

Test Plan:
- Reset release, imem ready every cycle, rsp 1 cycle after accept, data 0x3C010001, out_ready=1:
  - Request addresses are 0x3000, 0x3004, 0x3008 in order.
  - First out_valid carries out_pc=0x3000, out_instr=0x3C010001.
- out_ready=0 held:
  - Exactly QDEPTH=2 instructions are fetched (0x3000, 0x3004), then imem_req_valid=0.
  - Raising out_ready resumes fetch at 0x3008.
- redirect_valid with redirect_pc=0x3100 while the 0x3008 request is outstanding:
  - The late response is dropped and the queue is flushed.
  - The next request addr is 0x3100, and the next out_pc is 0x3100.
- exc_valid and redirect_valid (0x3200) in the same cycle -> the next request addr is 0x4180.
- Redirect coincides with the response for 0x3004 -> that response is not delivered and no stale out_valid appears. redirect_pc=0x3103 yields request addr 0x3100.
- Reset pulse mid-fetch with pc=0x3010 and 1 entry queued:
  - The next cycle has out_valid=0 and pc=0x3000.
  - Fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Types and reset/exception addresses shared by the fetch front end, PC and CP0 logic.
package fetch_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);
    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_pop;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign count  = cnt_q;
    assign head   = mem_q[rptr_q];
    assign do_pop = pop & ~empty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = push_data;
                wptr_d        = wptr_q + 1'b1;
            end
            if (do_pop) rptr_d = rptr_q + 1'b1;
            cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem requests, response
// drop after redirects, and a small instruction queue toward decode.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [31:0] EXC_VEC  = fetch_pkg::EXC_VEC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [31:0]  pc_q, pc_d, req_pc_q, req_pc_d, target;
    logic         outst_q, outst_d, drop_q, drop_d;
    logic         redir, accept, rsp_hit, push, pop;
    fetch_entry_t head;
    logic [AW:0]  count;
    logic         q_empty, q_full;

    // Issue depends on registered state only; redirect never gates it.
    assign imem_req_valid = ~reset & ~outst_q & (count < (AW+1)'(QDEPTH));
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;

    assign redir   = exc_valid | redirect_valid;
    assign target  = exc_valid ? EXC_VEC : redirect_pc;
    assign accept  = imem_req_valid & imem_req_ready;
    assign rsp_hit = imem_rsp_valid & outst_q;
    assign push    = rsp_hit & ~drop_q & ~redir & ~q_full;
    assign pop     = out_valid & out_ready;

    assign out_valid = ~q_empty;
    assign out_instr = q_empty ? '0 : head.instr;
    assign out_pc    = q_empty ? '0 : head.pc;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        if (rsp_hit) begin
            outst_d = 1'b0;
            drop_d  = 1'b0;
        end
        if (accept) begin
            outst_d  = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
        // Anything still in flight after a redirect belongs to the old path.
        if (redir) begin
            pc_d   = {target[31:2], 2'b00};
            drop_d = outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            outst_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redir),
        .push_data ('{pc: req_pc_q, instr: imem_rsp_data}),
        .head      (head),
        .count     (count),
        .empty     (q_empty),
        .full      (q_full)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Fetch unit bench: queue-based reference model plus in-order memory model, directed scenarios then random traffic.
module tb_if_fetch_unit;
    import fetch_pkg::*;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc, imem_req_addr, imem_rsp_data = '0, redirect_pc = '0, out_instr, out_pc;
    logic        imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
    logic        redirect_valid = 1'b0, exc_valid = 1'b0, out_valid, out_ready = 1'b0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_valid(exc_valid),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
    );

    int tests = 0, fails = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [31:0]  m_pc = RESET_PC, m_req_pc = '0;
    bit           m_out = 0, m_drop = 0;
    fetch_entry_t m_q[$];

    // memory model: one in-order response queue
    typedef struct { logic [31:0] data; int due; } mreq_t;
    mreq_t mem_q[$];
    int    cyc = 0;

    // stimulus knobs
    bit          k_rst = 1, k_ready = 1, k_ordy = 1, k_redir = 0, k_exc = 0, k_rand = 0;
    logic [31:0] k_rpc = '0;
    int          k_delay = 0;

    logic [31:0]  acc_log[$];
    fetch_entry_t pop_log[$];

    function automatic logic [31:0] acc_at(int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic fetch_entry_t pop_at(int i);
        fetch_entry_t e;
        e = '{pc: 32'hDEAD_DEAD, instr: 32'hDEAD_DEAD};
        if (i < pop_log.size()) e = pop_log[i];
        return e;
    endfunction

    task automatic step();
        bit          mrsp, mv, redir, acc, rsp;
        logic [31:0] mdata;
        @(negedge clk);
        mrsp  = 0;
        mdata = $urandom;
        if (mem_q.size() > 0 && cyc >= mem_q[0].due && (!k_rand || $urandom_range(3) != 0)) begin
            mrsp  = 1;
            mdata = mem_q[0].data;
        end else if (k_rand && mem_q.size() == 0 && $urandom_range(15) == 0) begin
            mrsp = 1;
        end
        reset          = k_rst;
        imem_req_ready = k_ready;
        imem_rsp_valid = mrsp;
        imem_rsp_data  = mdata;
        redirect_valid = k_redir;
        redirect_pc    = k_rpc;
        exc_valid      = k_exc;
        out_ready      = k_ordy;
        mv = !k_rst && !m_out && (m_q.size() < QD);
        #1;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, mv});
        chk("pc", pc, m_pc);
        chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
        chk("out_pc", out_pc, (m_q.size() > 0) ? m_q[0].pc : 32'd0);
        chk("out_instr", out_instr, (m_q.size() > 0) ? m_q[0].instr : 32'd0);
        @(posedge clk);
        if (k_rst) begin
            mem_q.delete();
            m_pc = RESET_PC; m_req_pc = '0; m_out = 0; m_drop = 0;
            m_q.delete();
        end else begin
            if (mrsp && mem_q.size() > 0) void'(mem_q.pop_front());
            redir = k_redir || k_exc;
            acc   = mv && k_ready;
            rsp   = mrsp && m_out;
            if (acc) begin
                mem_q.push_back('{data: (k_rand ? $urandom : 32'h3C01_0001), due: cyc + 1 + k_delay});
                acc_log.push_back(m_pc);
            end
            if (!redir && m_q.size() > 0 && k_ordy) pop_log.push_back(m_q.pop_front());
            if (rsp) begin
                if (!m_drop && !redir) m_q.push_back('{pc: m_req_pc, instr: mdata});
                m_out = 0; m_drop = 0;
            end
            if (acc) begin
                m_out = 1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                m_pc   = (k_exc ? EXC_VEC : k_rpc) & ~32'h3;
                m_q.delete();
                m_drop = m_out;
            end
        end
        cyc++;
    endtask

    task automatic rst_step();
        k_rst = 1; step(); k_rst = 0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        acc_log.delete(); pop_log.delete();
    endtask

    initial begin
        // reset state and streaming fetch
        rst_step(); rst_step(); #2;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        clear_logs();
        steps(8);
        chk("p1_addr0", acc_at(0), 32'h3000);
        chk("p1_addr1", acc_at(1), 32'h3004);
        chk("p1_addr2", acc_at(2), 32'h3008);
        chk("p1_first_pc", pop_at(0).pc, 32'h3000);
        chk("p1_first_instr", pop_at(0).instr, 32'h3C01_0001);

        // backpressure fills the queue, then redirect with an outstanding request
        rst_step(); clear_logs(); k_ordy = 0;
        steps(8); #2;
        chk("p2_fetched", acc_log.size(), 32'd2);
        chk("p2_addr1", acc_at(1), 32'h3004);
        chk("p2_stalled", {31'd0, imem_req_valid}, 32'd0);
        chk("p2_head_pc", out_pc, 32'h3000);
        k_ordy = 1; k_delay = 3; step();
        k_ordy = 0; step();
        chk("p2_resume", acc_at(2), 32'h3008);
        k_redir = 1; k_rpc = 32'h3100; step(); k_redir = 0; #2;
        chk("p2_flush", {31'd0, out_valid}, 32'd0);
        chk("p2_redir_pc", pc, 32'h3100);
        clear_logs(); k_ordy = 1; k_delay = 0;
        steps(10);
        chk("p2_next_addr", acc_at(0), 32'h3100);
        chk("p2_next_out", pop_at(0).pc, 32'h3100);

        // exception beats redirect
        k_exc = 1; k_redir = 1; k_rpc = 32'h3200; step();
        k_exc = 0; k_redir = 0; clear_logs();
        steps(8);
        chk("p3_exc_addr", acc_at(0), 32'h4180);
        chk("p3_exc_out", pop_at(0).pc, 32'h4180);

        // redirect in the same cycle as the 0x3004 response
        rst_step(); clear_logs();
        steps(3);
        chk("p4_setup", acc_at(1), 32'h3004);
        k_redir = 1; k_rpc = 32'h3103; step(); k_redir = 0; #2;
        chk("p4_no_stale", {31'd0, out_valid}, 32'd0);
        chk("p4_aligned_pc", pc, 32'h3100);
        clear_logs();
        steps(6);
        chk("p4_next_addr", acc_at(0), 32'h3100);
        chk("p4_next_out", pop_at(0).pc, 32'h3100);

        // reset mid-fetch with one entry queued
        rst_step(); clear_logs();
        steps(8); #2;
        chk("p5_pre_pc", pc, 32'h3010);
        chk("p5_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("p5_pre_head", out_pc, 32'h300C);
        rst_step(); #2;
        chk("p5_post_valid", {31'd0, out_valid}, 32'd0);
        chk("p5_post_pc", pc, 32'h3000);
        clear_logs();
        steps(4);
        chk("p5_restart", acc_at(0), 32'h3000);

        // random traffic
        k_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            k_rst   = ($urandom_range(99) == 0);
            k_ready = ($urandom_range(9) < 7);
            k_ordy  = ($urandom_range(9) < 6);
            k_exc   = ($urandom_range(31) == 0);
            k_redir = ($urandom_range(15) == 0);
            k_rpc   = 32'h3000 + $urandom_range(1023);
            k_delay = $urandom_range(3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
